dff_bank_arbiter: RTL and testbench
===================================

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8: data width of the shared register.
REQ-003 SHALL have parameter MAX_HOLD, default 4: maximum consecutive locked transfers per ownership (1..15).
REQ-004 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  N  per-requester write request.
REQ-007 SHALL have port lock  input  N  per-requester burst-hold request, qualified by req.
REQ-008 SHALL have port data  input  N*W  requester i data in bits [i*W+W-1 : i*W].
REQ-009 SHALL have port gnt  output  N  one-hot or zero grant, combinational from state and req.
REQ-010 SHALL have port q  output  W  shared register contents.
REQ-011 SHALL have port q_owner  output  clog2(N)  index of the last writer.
REQ-012 SHALL have port q_valid  output  1  high once any write has completed since reset.

Function
REQ-013 SHALL complete a transfer on each rising edge where req[i]&gnt[i]; q <= data[i], q_owner <= i, q_valid <= 1; latency is 1 cycle.
REQ-014 SHALL leave q, q_owner and q_valid unchanged on edges with no transfer.
REQ-015 SHALL assert at most one gnt bit per cycle, and only for a bit with req high.
REQ-016 SHALL implement FSM states IDLE and OWNED; the owner index and hold_cnt (4 bits) are valid only in OWNED.
REQ-017 In IDLE, SHALL grant the first requesting index at or after round-robin pointer ptr, searching upward modulo N.
REQ-018 In IDLE, after a transfer by winner w, SHALL set ptr <= (w+1) mod N; winner N-1 wraps ptr to 0.
REQ-019 In IDLE, if the winner also has lock high and MAX_HOLD>1, SHALL enter OWNED with owner=w, hold_cnt=1.
REQ-020 In OWNED, SHALL assert gnt only for owner, and only while req[owner] is high; all other requesters see gnt=0.
REQ-021 In OWNED, on each owner transfer SHALL increment hold_cnt.
REQ-022 In OWNED, SHALL return to IDLE with ptr=(owner+1) mod N on the edge where hold_cnt reaches MAX_HOLD, or where the owner transfers with lock low.
REQ-023 In OWNED, if req[owner] is low, SHALL grant nobody that cycle and return to IDLE with ptr=(owner+1) mod N (one bubble cycle).
REQ-024 SHALL make the IDLE grant decision in the same cycle req rises, with no added wait state.
REQ-025 Requesters SHALL hold data stable while req is high and gnt is low; the block does not capture ungranted data.
REQ-026 SHALL ignore lock when the corresponding req is low.

Reset
REQ-027 While rst is high, SHALL force gnt=0, and at the edge set q=0, q_owner=0, q_valid=0, ptr=0, hold_cnt=0, state=IDLE.
REQ-028 Reset asserted mid-burst SHALL abandon ownership; no transfer completes on that edge.
REQ-029 On the first cycle after rst falls, SHALL arbitrate normally from ptr=0.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, OWNED) and the hold-counter width constant in shared package arb_pkg.
REQ-031 SHALL implement the rotate-and-priority-pick as one sub-module, rr_pick (inputs: req, ptr; outputs: one-hot pick and index); all registers stay in dff_bank_arbiter.

Verification
REQ-032 Reset, then req=4'b0000 for 5 cycles -> gnt=0, q=0, q_valid=0 throughout.
REQ-033 req=4'b1111 held, lock=0, data[i]=8'h10+i -> gnt sequence 0001,0010,0100,1000,0001; q follows one cycle later: 10,11,12,13,10.
REQ-034 req=4'b0011, lock=4'b0001 held, MAX_HOLD=4 -> requester 0 granted 4 consecutive cycles, then requester 1 granted, then requester 0 again.
REQ-035 Owner 2 in OWNED drops req for one cycle -> that cycle gnt=0, state returns to IDLE, next grant goes to requester 3 when 3 is requesting.
REQ-036 rst asserted during owner 1's second locked transfer -> q=0 and q_valid=0 next cycle; first grant after release goes to the lowest requesting index.
REQ-037 Single requester 3 only, lock=0, 3 transfers -> ptr wraps to 0 each time; gnt=1000 every cycle; q_owner=3.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the dff_bank_arbiter block: FSM encoding and hold-counter width.
package arb_pkg;

  localparam int unsigned HoldW = 4;

  typedef enum logic {
    StIdle,
    StOwned
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first requesting index at or after ptr, searching upward mod N.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  int unsigned cand;

  // Walk from the farthest candidate down to ptr so the nearest requester is written last.
  always_comb begin
    pick = '0;
    idx  = '0;
    cand = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
        idx        = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shared W-bit register written by N requesters under round-robin arbitration with
// optional locked bursts of up to MAX_HOLD transfers.
module dff_bank_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4,
  localparam int unsigned IW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N*W-1:0]  data,
  output logic [N-1:0]    gnt,
  output logic [W-1:0]    q,
  output logic [IW-1:0]   q_owner,
  output logic            q_valid
);

  localparam logic [IW-1:0]    LastIdx = IW'(N - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [W-1:0]     q_q;
  logic [IW-1:0]    q_owner_q;
  logic             valid_q;

  logic [N-1:0]     pick;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    widx;
  logic             xfer;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LastIdx) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    gnt     = '0;
    widx    = owner_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          gnt  = pick;
          widx = pick_idx;
          if (|pick) begin
            ptr_d = next_idx(pick_idx);
            if (lock[pick_idx] && (MAX_HOLD > 1)) begin
              state_d = StOwned;
              owner_d = pick_idx;
              hold_d  = HoldW'(1);
            end
          end
        end
        StOwned: begin
          if (!req[owner_q]) begin
            // Owner went quiet: one bubble cycle, then fair arbitration resumes past it.
            state_d = StIdle;
            ptr_d   = next_idx(owner_q);
          end else begin
            gnt[owner_q] = 1'b1;
            hold_d       = hold_q + 1'b1;
            if ((hold_d == HoldMax) || !lock[owner_q]) begin
              state_d = StIdle;
              ptr_d   = next_idx(owner_q);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign xfer = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      q_q       <= '0;
      q_owner_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      if (xfer) begin
        q_q       <= data[widx*W +: W];
        q_owner_q <= widx;
        valid_q   <= 1'b1;
      end
    end
  end

  assign q       = q_q;
  assign q_owner = q_owner_q;
  assign q_valid = valid_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: hand-derived grant tables, scoreboarded register.
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_owner;
  logic        q_valid;

  typedef struct packed {
    logic [7:0] q;
    logic [1:0] owner;
    logic       valid;
  } exp_t;

  exp_t        sb[$];
  exp_t        mdl;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  dff_bank_arbiter #(
    .N(4),
    .W(8),
    .MAX_HOLD(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .data    (data),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; lock = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    mdl = '0;
    sb.delete();
  endtask

  // Scoreboard model of the shared register; the expected grant is a hand-derived constant.
  task automatic push_expect(input logic r, input logic [3:0] eg);
    if (r) mdl = '0;
    else if (eg != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          mdl.q     = data[i*8 +: 8];
          mdl.owner = 2'(i);
          mdl.valid = 1'b1;
        end
      end
    end
    sb.push_back(mdl);
  endtask

  task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] lk);
    @(negedge clk);
    rst = r; req = rq; lock = lk;
    #1;
  endtask

  task automatic test_reset();
    logic       rs [6];
    logic [3:0] rq [6];
    exp_t       e;
    rs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rq = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    do_reset();
    data = 32'h1312_1110;
    for (int i = 0; i < 6; i++) begin
      apply(rs[i], rq[i], 4'h0);
      n_run++;
      if (gnt !== 4'b0) begin
        n_fail++; $display("FAIL reset gnt cyc %0d: got %b want 0000", i, gnt);
      end
      push_expect(rs[i], 4'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({q, q_owner, q_valid} !== e) begin
        n_fail++;
        $display("FAIL reset regs cyc %0d: got q=%h own=%0d v=%b want q=%h own=%0d v=%b",
                 i, q, q_owner, q_valid, e.q, e.owner, e.valid);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rotate();
    logic [3:0] eg [5];
    exp_t       e;
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'hF, 4'h0);
      n_run++;
      if (gnt !== eg[i]) begin
        n_fail++; $display("FAIL rotate gnt cyc %0d: got %b want %b", i, gnt, eg[i]);
      end
      push_expect(1'b0, eg[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({q, q_owner, q_valid} !== e) begin
        n_fail++;
        $display("FAIL rotate regs cyc %0d: got q=%h own=%0d v=%b want q=%h own=%0d v=%b",
                 i, q, q_owner, q_valid, e.q, e.owner, e.valid);
      end
    end
  endtask

  task automatic test_lock_burst();
    logic [3:0] eg [6];
    exp_t       e;
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    do_reset();
    data = 32'h4433_2211;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 4'b0011, 4'b0001);
      n_run++;
      if (gnt !== eg[i]) begin
        n_fail++; $display("FAIL lock_burst gnt cyc %0d: got %b want %b", i, gnt, eg[i]);
      end
      push_expect(1'b0, eg[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({q, q_owner, q_valid} !== e) begin
        n_fail++;
        $display("FAIL lock_burst regs cyc %0d: got q=%h own=%0d v=%b want q=%h own=%0d v=%b",
                 i, q, q_owner, q_valid, e.q, e.owner, e.valid);
      end
    end
  endtask

  task automatic test_owner_drop();
    logic [3:0] rq [3];
    logic [3:0] lk [3];
    logic [3:0] eg [3];
    exp_t       e;
    rq = '{4'b0100, 4'b1000, 4'b1001};
    lk = '{4'b0100, 4'b0000, 4'b0000};
    eg = '{4'b0100, 4'b0000, 4'b1000};
    do_reset();
    data = 32'hD3C2_B1A0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, rq[i], lk[i]);
      n_run++;
      if (gnt !== eg[i]) begin
        n_fail++; $display("FAIL owner_drop gnt cyc %0d: got %b want %b", i, gnt, eg[i]);
      end
      push_expect(1'b0, eg[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({q, q_owner, q_valid} !== e) begin
        n_fail++;
        $display("FAIL owner_drop regs cyc %0d: got q=%h own=%0d v=%b want q=%h own=%0d v=%b",
                 i, q, q_owner, q_valid, e.q, e.owner, e.valid);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic       rs [3];
    logic [3:0] rq [3];
    logic [3:0] lk [3];
    logic [3:0] eg [3];
    exp_t       e;
    rs = '{1'b0, 1'b1, 1'b0};
    rq = '{4'b0010, 4'b0010, 4'b0110};
    lk = '{4'b0010, 4'b0010, 4'b0000};
    eg = '{4'b0010, 4'b0000, 4'b0010};
    do_reset();
    data = 32'h5E5C_5B5A;
    for (int i = 0; i < 3; i++) begin
      apply(rs[i], rq[i], lk[i]);
      n_run++;
      if (gnt !== eg[i]) begin
        n_fail++; $display("FAIL mid_reset gnt cyc %0d: got %b want %b", i, gnt, eg[i]);
      end
      push_expect(rs[i], eg[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({q, q_owner, q_valid} !== e) begin
        n_fail++;
        $display("FAIL mid_reset regs cyc %0d: got q=%h own=%0d v=%b want q=%h own=%0d v=%b",
                 i, q, q_owner, q_valid, e.q, e.owner, e.valid);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] rq [4];
    logic [3:0] lk [4];
    logic [3:0] eg [4];
    exp_t       e;
    rq = '{4'b1000, 4'b1000, 4'b1000, 4'b1001};
    lk = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
    eg = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
    do_reset();
    data = 32'hA3A2_A1A0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, rq[i], lk[i]);
      n_run++;
      if (gnt !== eg[i]) begin
        n_fail++; $display("FAIL back_to_back gnt cyc %0d: got %b want %b", i, gnt, eg[i]);
      end
      push_expect(1'b0, eg[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({q, q_owner, q_valid} !== e) begin
        n_fail++;
        $display("FAIL back_to_back regs cyc %0d: got q=%h own=%0d v=%b want q=%h own=%0d v=%b",
                 i, q, q_owner, q_valid, e.q, e.owner, e.valid);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    data = '0;
    mdl  = '0;
    test_reset();
    test_rotate();
    test_lock_burst();
    test_owner_drop();
    test_reset_mid_burst();
    test_back_to_back();
    n_run++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
